// File: rtl/bram_fifo_pkg.sv
// Shared constants and width helpers for the BRAM-backed streaming FIFO.
// Widths are derived from the BRAM address width of the instantiating block.
package bram_fifo_pkg;

    localparam int OUT_BUF_DEPTH = 2;
    localparam int OCC_W         = 2;
    localparam int DEF_ADDR_W    = 4;

    function automatic int fifo_depth(input int aw);
        return 2 ** aw;
    endfunction

    function automatic int mem_cnt_w(input int aw);
        return aw + 1;
    endfunction

    function automatic int count_w(input int aw);
        return aw + 2;
    endfunction

    localparam int DEF_DEPTH = fifo_depth(DEF_ADDR_W);

endpackage

// File: rtl/bram_fifo_outbuf.sv
// Two-entry output/skid buffer absorbing the BRAM's registered read latency.
// Tracks the in-flight read so the issue logic can see total occupancy.
module bram_fifo_outbuf
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Issue,
    input  logic [DATA_WIDTH-1:0] i_Bram_Rd_Data,
    input  logic                  i_Rd_Ready,
    output logic                  o_Rd_Valid,
    output logic [DATA_WIDTH-1:0] o_Rd_Data,
    output logic                  o_Pop,
    output logic [OCC_W-1:0]      o_Occ
);

    logic                  inflight_q;
    logic                  out_v_q;
    logic                  out_v_d;
    logic                  skid_v_q;
    logic                  skid_v_d;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] out_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;
    logic                  pop;

    assign pop = out_v_q & i_Rd_Ready;

    // Returning word goes to the head slot whenever that slot frees up this edge
    always_comb begin
        out_v_d  = out_v_q;
        skid_v_d = skid_v_q;
        out_d    = out_q;
        skid_d   = skid_q;
        if (inflight_q) begin
            if (!out_v_q || (pop && !skid_v_q)) begin
                out_d   = i_Bram_Rd_Data;
                out_v_d = 1'b1;
            end else if (pop) begin
                out_d    = skid_q;
                skid_d   = i_Bram_Rd_Data;
                skid_v_d = 1'b1;
            end else begin
                skid_d   = i_Bram_Rd_Data;
                skid_v_d = 1'b1;
            end
        end else if (pop) begin
            if (skid_v_q) begin
                out_d    = skid_q;
                skid_v_d = 1'b0;
            end else begin
                out_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            inflight_q <= 1'b0;
            out_v_q    <= 1'b0;
            skid_v_q   <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            inflight_q <= i_Issue;
            out_v_q    <= out_v_d;
            skid_v_q   <= skid_v_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    assign o_Rd_Valid = out_v_q;
    assign o_Rd_Data  = out_q;
    assign o_Pop      = pop;
    assign o_Occ      = OCC_W'({1'b0, out_v_q})
                      + OCC_W'({1'b0, skid_v_q})
                      + OCC_W'({1'b0, inflight_q});

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Pointer/flow-control stage turning a simple dual-port BRAM into a FIFO.
// Optional BRAM_FIFO_AFULL_EN adds a registered o_Almost_Full output.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Wr_Valid,
    output logic                  o_Wr_Ready,
    input  logic [DATA_WIDTH-1:0] i_Wr_Data,
    output logic                  o_Rd_Valid,
    input  logic                  i_Rd_Ready,
    output logic [DATA_WIDTH-1:0] o_Rd_Data,
    output logic                  o_Bram_Wr_En,
    output logic [ADDR_WIDTH-1:0] o_Bram_W_Addr,
    output logic [DATA_WIDTH-1:0] o_Bram_Wr_Data,
    output logic                  o_Bram_Rd_En,
    output logic [ADDR_WIDTH-1:0] o_Bram_R_Addr,
    input  logic [DATA_WIDTH-1:0] i_Bram_Rd_Data,
    output logic [ADDR_WIDTH+1:0] o_Count,
    output logic                  o_Full,
    output logic                  o_Empty
`ifdef BRAM_FIFO_AFULL_EN
    ,
    output logic                  o_Almost_Full
`endif
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int MW    = mem_cnt_w(ADDR_WIDTH);
    localparam int CW    = count_w(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_d;
    logic [MW-1:0]         mem_cnt_q;
    logic [MW-1:0]         mem_cnt_d;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  full_q;
    logic                  full_d;
    logic                  wr_acc;
    logic                  rd_iss;
    logic                  pop;
    logic [OCC_W-1:0]      occ;
    logic [OCC_W:0]        occ_net;

    assign o_Wr_Ready = i_Rst_L & ~full_q;
    assign wr_acc     = i_Wr_Valid & o_Wr_Ready;

    // Issue only while the buffer plus in-flight read leaves a free slot
    assign occ_net = {1'b0, occ} - {{OCC_W{1'b0}}, pop};
    assign rd_iss  = i_Rst_L
                   & (mem_cnt_q != '0)
                   & (occ_net < (OCC_W+1)'(OUT_BUF_DEPTH));

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_cnt_d = mem_cnt_q;
        count_d   = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_iss) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        unique case (1'b1)
            (wr_acc & ~rd_iss): mem_cnt_d = mem_cnt_q + MW'(1);
            (~wr_acc & rd_iss): mem_cnt_d = mem_cnt_q - MW'(1);
            default:            mem_cnt_d = mem_cnt_q;
        endcase
        unique case (1'b1)
            (wr_acc & ~pop): count_d = count_q + CW'(1);
            (~wr_acc & pop): count_d = count_q - CW'(1);
            default:         count_d = count_q;
        endcase
        full_d = (mem_cnt_d == MW'(DEPTH));
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            count_q   <= count_d;
            full_q    <= full_d;
        end
    end

`ifdef BRAM_FIFO_AFULL_EN
    logic afull_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= (mem_cnt_d >= MW'(AFULL_LEVEL));
        end
    end

    assign o_Almost_Full = afull_q;
`else
`endif

    bram_fifo_outbuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_outbuf (
        .i_Clk          (i_Clk),
        .i_Rst_L        (i_Rst_L),
        .i_Issue        (rd_iss),
        .i_Bram_Rd_Data (i_Bram_Rd_Data),
        .i_Rd_Ready     (i_Rd_Ready),
        .o_Rd_Valid     (o_Rd_Valid),
        .o_Rd_Data      (o_Rd_Data),
        .o_Pop          (pop),
        .o_Occ          (occ)
    );

    assign o_Bram_Wr_En   = wr_acc;
    assign o_Bram_W_Addr  = wr_ptr_q;
    assign o_Bram_Wr_Data = i_Wr_Data;
    assign o_Bram_Rd_En   = rd_iss;
    assign o_Bram_R_Addr  = rd_ptr_q;
    assign o_Count        = count_q;
    assign o_Full         = full_q;
    assign o_Empty        = (count_q == '0);

endmodule
